// File: rtl/dht_read_scheduler_pkg.sv
// Shared types and constants for the DHT11 read scheduler: FSM states, frame byte
// offsets and default timing.
package dht_read_scheduler_pkg;

  localparam int unsigned CntW = 28;

  localparam int unsigned DefPeriodCyc   = 200_000_000;
  localparam int unsigned DefTimeoutCyc  = 2_500_000;
  localparam int unsigned DefRetryGapCyc = 100_000_000;
  localparam int unsigned DefMaxRetry    = 3;
  localparam logic [7:0]  DefHyst        = 8'd1;

  // LSB positions of the byte fields in {hum_int, hum_dec, temp_int, temp_dec, checksum}
  localparam int unsigned HumIntLsb  = 32;
  localparam int unsigned HumDecLsb  = 24;
  localparam int unsigned TempIntLsb = 16;
  localparam int unsigned TempDecLsb = 8;
  localparam int unsigned SumLsb     = 0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitDone,
    StCheck,
    StWaitPeriod,
    StRetryGap,
    StFault
  } state_e;

endpackage

// File: rtl/dht_checksum.sv
// Combinational DHT11 frame check: low byte must equal the mod-256 sum of the upper four.
module dht_checksum
  import dht_read_scheduler_pkg::*;
(
  input  logic [39:0] frame,
  output logic        pass
);

  logic [7:0] sum;

  always_comb begin
    sum  = frame[HumIntLsb +: 8] + frame[HumDecLsb +: 8] +
           frame[TempIntLsb +: 8] + frame[TempDecLsb +: 8];
    pass = (sum == frame[SumLsb +: 8]);
  end

endmodule

// File: rtl/dht_read_scheduler.sv
// Paces DHT11 reads, retries failed attempts, latches valid readings and drives the
// fan/heater enables with hysteresis.
module dht_read_scheduler
  import dht_read_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_CYC    = DefPeriodCyc,
  parameter int unsigned TIMEOUT_CYC   = DefTimeoutCyc,
  parameter int unsigned RETRY_GAP_CYC = DefRetryGapCyc,
  parameter int unsigned MAX_RETRY     = DefMaxRetry,
  parameter logic [7:0]  HYST          = DefHyst
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        read_req_i,
  input  logic        clr_fault_i,
  input  logic        frame_done_i,
  input  logic [39:0] frame_i,
  input  logic [7:0]  temp_hi_i,
  input  logic [7:0]  temp_lo_i,
  output logic        start_o,
  output logic [7:0]  temp_o,
  output logic [7:0]  hum_o,
  output logic        valid_o,
  output logic [7:0]  err_cnt_o,
  output logic        fault_o,
  output logic        fan_o,
  output logic        heater_o
);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] since_q;
  logic [39:0]     frame_q;
  logic [7:0]      temp_q, hum_q, err_q, retry_q;
  logic            valid_q, have_q;
  logic            fan_q, fan_d, heater_q, heater_d;
  logic            sum_ok, attempt_ok, attempt_fail;
  logic            misconfig;
  logic signed [9:0] t_s, hi_s, lo_s, hyst_s;

  dht_checksum u_checksum (
    .frame (frame_q),
    .pass  (sum_ok)
  );

  // Each timed state is occupied for exactly its load value + 1 cycles; START plus
  // WAIT_DONE together span TIMEOUT_CYC cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    attempt_ok   = 1'b0;
    attempt_fail = 1'b0;
    unique case (state_q)
      StIdle: state_d = StStart;
      StStart: begin
        state_d = StWaitDone;
        cnt_d   = CntW'(TIMEOUT_CYC - 2);
      end
      StWaitDone: begin
        if (frame_done_i) begin
          state_d = StCheck;
        end else if (cnt_q == '0) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCheck: begin
        if (sum_ok) begin
          attempt_ok = 1'b1;
          state_d    = StWaitPeriod;
          cnt_d      = CntW'(PERIOD_CYC - 1);
        end else begin
          attempt_fail = 1'b1;
        end
      end
      StWaitPeriod: begin
        if (cnt_q == '0 || (read_req_i && since_q >= CntW'(RETRY_GAP_CYC))) begin
          state_d = StStart;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRetryGap: begin
        if (cnt_q == '0) begin
          state_d = StStart;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFault: begin
        if (clr_fault_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (attempt_fail) begin
      if (retry_q + 8'd1 == 8'(MAX_RETRY)) begin
        state_d = StFault;
      end else begin
        state_d = StRetryGap;
        cnt_d   = CntW'(RETRY_GAP_CYC - 1);
      end
    end
  end

  // One spare bit beyond 9 so that lo + HYST cannot wrap either.
  always_comb begin
    t_s       = $signed({2'b00, temp_q});
    hi_s      = $signed({2'b00, temp_hi_i});
    lo_s      = $signed({2'b00, temp_lo_i});
    hyst_s    = $signed({2'b00, HYST});
    misconfig = (temp_lo_i >= temp_hi_i);
    fan_d     = fan_q;
    heater_d  = heater_q;
    if (t_s >= hi_s) begin
      fan_d = 1'b1;
    end else if (t_s < hi_s - hyst_s) begin
      fan_d = 1'b0;
    end
    if (t_s <= lo_s) begin
      heater_d = 1'b1;
    end else if (t_s > lo_s + hyst_s) begin
      heater_d = 1'b0;
    end
    if (fan_d) heater_d = 1'b0;
    if (!have_q || misconfig || state_q == StFault) begin
      fan_d    = 1'b0;
      heater_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      since_q  <= '0;
      frame_q  <= '0;
      temp_q   <= '0;
      hum_q    <= '0;
      err_q    <= '0;
      retry_q  <= '0;
      valid_q  <= 1'b0;
      have_q   <= 1'b0;
      fan_q    <= 1'b0;
      heater_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Cycles elapsed since the last start_o, saturating; gates early reads.
      if (state_q == StStart) begin
        since_q <= CntW'(1);
      end else if (since_q != '1) begin
        since_q <= since_q + 1'b1;
      end
      if (state_q == StWaitDone && frame_done_i) frame_q <= frame_i;
      valid_q <= attempt_ok;
      if (attempt_ok) begin
        temp_q <= frame_q[TempIntLsb +: 8];
        hum_q  <= frame_q[HumIntLsb +: 8];
        have_q <= 1'b1;
      end
      if (attempt_fail && err_q != 8'hFF) err_q <= err_q + 8'd1;
      if (attempt_ok) begin
        retry_q <= '0;
      end else if (attempt_fail) begin
        retry_q <= retry_q + 8'd1;
      end else if (state_q == StFault && clr_fault_i) begin
        retry_q <= '0;
      end
      fan_q    <= fan_d;
      heater_q <= heater_d;
    end
  end

  assign start_o   = (state_q == StStart);
  assign fault_o   = (state_q == StFault);
  assign valid_o   = valid_q;
  assign temp_o    = temp_q;
  assign hum_o     = hum_q;
  assign err_cnt_o = err_q;
  assign fan_o     = fan_q && !fault_o;
  assign heater_o  = heater_q && !fault_o;

endmodule

// File: tb/tb_dht_read_scheduler.sv
// Directed bench for dht_read_scheduler with shortened timing (1000/100/200 cycles).
module tb_dht_read_scheduler;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        read_req_i;
  logic        clr_fault_i;
  logic        frame_done_i;
  logic [39:0] frame_i;
  logic [7:0]  temp_hi_i, temp_lo_i;
  logic        start_o, valid_o, fault_o, fan_o, heater_o;
  logic [7:0]  temp_o, hum_o, err_cnt_o;

  int checks = 0;
  int errors = 0;

  dht_read_scheduler #(
    .PERIOD_CYC    (1000),
    .TIMEOUT_CYC   (100),
    .RETRY_GAP_CYC (200)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .read_req_i   (read_req_i),
    .clr_fault_i  (clr_fault_i),
    .frame_done_i (frame_done_i),
    .frame_i      (frame_i),
    .temp_hi_i    (temp_hi_i),
    .temp_lo_i    (temp_lo_i),
    .start_o      (start_o),
    .temp_o       (temp_o),
    .hum_o        (hum_o),
    .valid_o      (valid_o),
    .err_cnt_o    (err_cnt_o),
    .fault_o      (fault_o),
    .fan_o        (fan_o),
    .heater_o     (heater_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int max_cyc);
    int n = 0;
    while (start_o !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check("start_within_bound", start_o, 1'b1);
  endtask

  // Called in the start_o cycle; returns in the valid_o cycle.
  task automatic do_read(input logic [7:0] hum, input logic [7:0] temp);
    logic [7:0] sum;
    sum = hum + temp;
    repeat (20) step();
    frame_done_i = 1'b1;
    frame_i      = {hum, 8'h00, temp, 8'h00, sum};
    step();
    frame_done_i = 1'b0;
    check("valid_low_in_check", valid_o, 1'b0);
    step();
    check("valid_pulse", valid_o, 1'b1);
    check("temp_latched", temp_o, temp);
    check("hum_latched", hum_o, hum);
  endtask

  initial begin
    rst_ni       = 1'b0;
    read_req_i   = 1'b0;
    clr_fault_i  = 1'b0;
    frame_done_i = 1'b0;
    frame_i      = '0;
    temp_hi_i    = 8'd30;
    temp_lo_i    = 8'd18;
    repeat (3) step();

    check("rst_start", start_o, 1'b0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_fault", fault_o, 1'b0);
    check("rst_fan", fan_o, 1'b0);
    check("rst_heater", heater_o, 1'b0);
    check("rst_temp", temp_o, 8'h00);
    check("rst_hum", hum_o, 8'h00);
    check("rst_err", err_cnt_o, 8'h00);

    rst_ni = 1'b1;
    check("idle_after_release", start_o, 1'b0);
    step();
    check("start_after_release", start_o, 1'b1);
    step();
    check("start_one_cycle", start_o, 1'b0);

    // Nominal frame 0x3700190050, done 20 cycles after start_o
    repeat (19) step();
    frame_done_i = 1'b1;
    frame_i      = 40'h37_00_19_00_50;
    step();
    frame_done_i = 1'b0;
    step();
    check("nominal_valid", valid_o, 1'b1);
    check("nominal_hum", hum_o, 8'h37);
    check("nominal_temp", temp_o, 8'h19);
    step();
    check("valid_one_cycle", valid_o, 1'b0);
    check("fan_at_25", fan_o, 1'b0);
    check("heater_at_25", heater_o, 1'b0);
    repeat (998) step();
    check("no_start_before_period", start_o, 1'b0);
    step();
    check("start_after_period", start_o, 1'b1);

    // Fan hysteresis, plus early read request window
    do_read(8'h28, 8'd30);
    step();
    check("fan_at_30", fan_o, 1'b1);
    check("heater_at_30", heater_o, 1'b0);
    repeat (49) step();
    read_req_i = 1'b1;
    step();
    read_req_i = 1'b0;
    check("early_req_too_soon", start_o, 1'b0);
    repeat (199) step();
    read_req_i = 1'b1;
    step();
    read_req_i = 1'b0;
    check("early_req_accepted", start_o, 1'b1);

    do_read(8'h28, 8'd29);
    step();
    check("fan_hold_at_29", fan_o, 1'b1);
    read_req_i = 1'b1;
    wait_start(400);
    read_req_i = 1'b0;
    do_read(8'h28, 8'd28);
    step();
    check("fan_off_at_28", fan_o, 1'b0);
    check("heater_at_28", heater_o, 1'b0);

    // Heater hysteresis and misconfiguration
    read_req_i = 1'b1;
    wait_start(400);
    read_req_i = 1'b0;
    do_read(8'h28, 8'd18);
    step();
    check("heater_on_at_18", heater_o, 1'b1);
    check("fan_off_at_18", fan_o, 1'b0);
    temp_lo_i = 8'd40;
    step();
    check("misconfig_heater", heater_o, 1'b0);
    check("misconfig_fan", fan_o, 1'b0);
    temp_lo_i = 8'd18;
    step();
    check("heater_restored", heater_o, 1'b1);
    read_req_i = 1'b1;
    wait_start(400);
    read_req_i = 1'b0;
    do_read(8'h28, 8'd19);
    step();
    check("heater_hold_at_19", heater_o, 1'b1);
    read_req_i = 1'b1;
    wait_start(400);
    read_req_i = 1'b0;
    do_read(8'h28, 8'd20);
    step();
    check("heater_off_at_20", heater_o, 1'b0);

    // Bad checksum; read_req_i held high to show it is ignored in the retry gap
    read_req_i = 1'b1;
    wait_start(400);
    repeat (20) step();
    frame_done_i = 1'b1;
    frame_i      = 40'h37_00_19_00_51;
    step();
    frame_done_i = 1'b0;
    step();
    check("badsum_no_valid", valid_o, 1'b0);
    check("badsum_err_cnt", err_cnt_o, 8'd1);
    check("badsum_temp_hold", temp_o, 8'd20);
    repeat (199) step();
    check("retry_gap_no_start", start_o, 1'b0);
    step();
    check("retry_gap_start", start_o, 1'b1);
    read_req_i = 1'b0;
    do_read(8'h28, 8'd18);
    step();
    check("heater_before_fault", heater_o, 1'b1);

    // Three timeouts in a row -> FAULT
    read_req_i = 1'b1;
    wait_start(400);
    read_req_i = 1'b0;
    repeat (299) step();
    check("timeout1_no_start", start_o, 1'b0);
    step();
    check("timeout1_restart", start_o, 1'b1);
    check("timeout1_err", err_cnt_o, 8'd2);
    repeat (299) step();
    check("timeout2_no_start", start_o, 1'b0);
    step();
    check("timeout2_restart", start_o, 1'b1);
    check("timeout2_err", err_cnt_o, 8'd3);
    repeat (99) step();
    check("fault_not_yet", fault_o, 1'b0);
    step();
    check("fault_set", fault_o, 1'b1);
    check("fault_err", err_cnt_o, 8'd4);
    check("fault_heater_off", heater_o, 1'b0);
    check("fault_no_start", start_o, 1'b0);

    // frame_done_i outside WAIT_DONE is ignored
    frame_done_i = 1'b1;
    frame_i      = 40'h37_00_19_00_50;
    step();
    frame_done_i = 1'b0;
    step();
    check("stray_done_no_valid", valid_o, 1'b0);
    check("fault_temp_hold", temp_o, 8'd18);
    repeat (50) step();
    check("fault_persists", fault_o, 1'b1);
    clr_fault_i = 1'b1;
    step();
    clr_fault_i = 1'b0;
    check("clr_leaves_fault", fault_o, 1'b0);
    check("clr_idle_no_start", start_o, 1'b0);
    step();
    check("clr_start", start_o, 1'b1);

    // Reset during WAIT_DONE with a frame arriving
    repeat (5) step();
    rst_ni       = 1'b0;
    frame_done_i = 1'b1;
    frame_i      = 40'h37_00_19_00_50;
    step();
    frame_done_i = 1'b0;
    check("midread_rst_valid", valid_o, 1'b0);
    check("midread_rst_temp", temp_o, 8'h00);
    check("midread_rst_err", err_cnt_o, 8'h00);
    check("midread_rst_heater", heater_o, 1'b0);
    step();
    check("midread_rst_valid2", valid_o, 1'b0);
    rst_ni = 1'b1;
    check("midread_release_idle", start_o, 1'b0);
    step();
    check("midread_release_start", start_o, 1'b1);
    check("midread_release_valid", valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
